eth_frame_rx_parser: RTL

//  Receive-side frame parser: the line-side counterpart of the byte-wide Ethernet transmitter.

---
 rtl/eth_frame_rx_parser.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/eth_frame_rx_parser.sv
// rtl/eth_frame_rx_parser.sv - receive-side Ethernet frame parser: preamble strip, header extract,
// address filter, FCS-stripped payload stream, CRC-32 and length status.
module eth_frame_rx_parser #(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518,
   parameter bit PROMISC   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data_in,
   input  logic        rx_valid,
   input  logic        rx_last,
   input  logic [47:0] local_mac,
   output logic        hdr_valid,
   output logic [47:0] dest_mac,
   output logic [47:0] src_mac,
   output logic [15:0] ethertype,
   output logic [7:0]  rx_data_out,
   output logic        rx_data_vld,
   output logic        rx_data_last,
   output logic        frame_done,
   output logic        frame_ok,
   output logic        err_crc,
   output logic        err_len
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_DROP} state_t;

   localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_L = 11'(MAX_FRAME);

   state_t        state_q, state_d;
   logic [10:0]   len_q, len_d, len_inc;
   logic [31:0]   crc_q, crc_d, crc_nxt;
   logic [111:0]  hdr_q, hdr_d, hdr_nxt;
   logic [31:0]   dl_q, dl_d;
   logic [2:0]    dl_cnt_q, dl_cnt_d;
   logic [47:0]   dest_q, dest_d, src_q, src_d;
   logic [15:0]   type_q, type_d;
   logic [7:0]    dout_q, dout_d;
   logic          hvld_q, hvld_d, dvld_q, dvld_d, dlast_q, dlast_d;
   logic          done_q, done_d, ok_q, ok_d, ecrc_q, ecrc_d, elen_q, elen_d;
   logic          addr_ok, status, force_len;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   always_comb begin
      len_inc = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
      crc_nxt = crc_byte(crc_q, rx_data_in);
      hdr_nxt = {hdr_q[103:0], rx_data_in};
      // Only meaningful on the 6th header byte, when hdr_nxt[47:0] holds the full dest MAC.
      addr_ok = PROMISC || (hdr_nxt[47:0] == local_mac) || (hdr_nxt[47:0] == 48'hFFFF_FFFF_FFFF);

      state_d   = state_q;
      len_d     = len_q;
      crc_d     = crc_q;
      hdr_d     = hdr_q;
      dl_d      = dl_q;
      dl_cnt_d  = dl_cnt_q;
      dest_d    = dest_q;
      src_d     = src_q;
      type_d    = type_q;
      dout_d    = dout_q;
      hvld_d    = 1'b0;
      dvld_d    = 1'b0;
      dlast_d   = 1'b0;
      done_d    = 1'b0;
      ok_d      = 1'b0;
      ecrc_d    = 1'b0;
      elen_d    = 1'b0;
      status    = 1'b0;
      force_len = 1'b0;

      if (rx_valid) begin
         case (state_q)
            S_IDLE: if (rx_data_in == 8'h55) state_d = S_PRE;
            S_PRE: begin
               if (rx_data_in == 8'hD5) begin
                  state_d  = S_HDR;
                  len_d    = '0;
                  crc_d    = 32'hFFFF_FFFF;
                  dl_cnt_d = '0;
                  dl_d     = '0;
               end else if (rx_data_in != 8'h55) begin
                  state_d = S_DROP;
               end
            end
            S_HDR: begin
               len_d = len_inc;
               crc_d = crc_nxt;
               hdr_d = hdr_nxt;
               if (len_q == 11'd5 && !addr_ok) begin
                  state_d = S_DROP;
               end else if (len_q == 11'd13) begin
                  state_d = S_PAY;
                  hvld_d  = 1'b1;
                  dest_d  = hdr_nxt[111:64];
                  src_d   = hdr_nxt[63:16];
                  type_d  = hdr_nxt[15:0];
               end
               status    = rx_last && (len_q > 11'd5 || (len_q == 11'd5 && addr_ok));
               force_len = 1'b1;
            end
            S_PAY: begin
               len_d    = len_inc;
               crc_d    = crc_nxt;
               dl_d     = {dl_q[23:0], rx_data_in};
               dl_cnt_d = (dl_cnt_q == 3'd4) ? 3'd4 : dl_cnt_q + 3'd1;
               // Emitted byte sits 4 positions back, so len_inc <= MAX keeps it clear of the max-frame FCS.
               if (dl_cnt_q == 3'd4 && len_inc <= MAX_L) begin
                  dout_d  = dl_q[31:24];
                  dvld_d  = 1'b1;
                  dlast_d = rx_last;
               end
               status = rx_last;
            end
            default: ;
         endcase
         if (status) begin
            done_d = 1'b1;
            ecrc_d = (crc_nxt != 32'hDEBB_20E3);
            elen_d = force_len || (len_inc < MIN_L) || (len_inc > MAX_L);
            ok_d   = !((crc_nxt != 32'hDEBB_20E3) || force_len || (len_inc < MIN_L) || (len_inc > MAX_L));
         end
         if (rx_last) state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         crc_q    <= 32'hFFFF_FFFF;
         hdr_q    <= '0;
         dl_q     <= '0;
         dl_cnt_q <= '0;
         dest_q   <= '0;
         src_q    <= '0;
         type_q   <= '0;
         dout_q   <= '0;
         hvld_q   <= 1'b0;
         dvld_q   <= 1'b0;
         dlast_q  <= 1'b0;
         done_q   <= 1'b0;
         ok_q     <= 1'b0;
         ecrc_q   <= 1'b0;
         elen_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         crc_q    <= crc_d;
         hdr_q    <= hdr_d;
         dl_q     <= dl_d;
         dl_cnt_q <= dl_cnt_d;
         dest_q   <= dest_d;
         src_q    <= src_d;
         type_q   <= type_d;
         dout_q   <= dout_d;
         hvld_q   <= hvld_d;
         dvld_q   <= dvld_d;
         dlast_q  <= dlast_d;
         done_q   <= done_d;
         ok_q     <= ok_d;
         ecrc_q   <= ecrc_d;
         elen_q   <= elen_d;
      end
   end

   assign hdr_valid    = hvld_q;
   assign dest_mac     = dest_q;
   assign src_mac      = src_q;
   assign ethertype    = type_q;
   assign rx_data_out  = dout_q;
   assign rx_data_vld  = dvld_q;
   assign rx_data_last = dlast_q;
   assign frame_done   = done_q;
   assign frame_ok     = ok_q;
   assign err_crc      = ecrc_q;
   assign err_len      = elen_q;

endmodule
